// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank for the AES core control/status block.
// NUM_REGS registers of DATA_WIDTH bits, each either read/write or read-only.
// A read-only register returns its hw_in slice on reads.
// Writes honour WSTRB byte lanes and raise a one-cycle wr_pulse on commit.
// Bad accesses (read-only target or out-of-range index) answer with SLVERR.
module axi_lite_regbank #(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  NUM_REGS   = 8,
  parameter int                  ADDR_WIDTH = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                           s00_axi_aclk,
  input  logic                           s00_axi_areset,
  input  logic [ADDR_WIDTH-1:0]          s00_axi_awaddr,
  input  logic [2:0]                     s00_axi_awprot,
  input  logic                           s00_axi_awvalid,
  output logic                           s00_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s00_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s00_axi_wstrb,
  input  logic                           s00_axi_wvalid,
  output logic                           s00_axi_wready,
  output logic [1:0]                     s00_axi_bresp,
  output logic                           s00_axi_bvalid,
  input  logic                           s00_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s00_axi_araddr,
  input  logic [2:0]                     s00_axi_arprot,
  input  logic                           s00_axi_arvalid,
  output logic                           s00_axi_arready,
  output logic [DATA_WIDTH-1:0]          s00_axi_rdata,
  output logic [1:0]                     s00_axi_rresp,
  output logic                           s00_axi_rvalid,
  input  logic                           s00_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
  localparam int IDX_W1   = IDX_W + 1;
  localparam logic [IDX_W1-1:0] REG_CNT = IDX_W1'(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  w_state_t              w_state_q, w_state_d;
  logic                  aw_held_q, w_held_q;
  logic [IDX_W-1:0]      aw_idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic [1:0]            bresp_q;
  logic                  aw_hs, w_hs, wr_ro, wr_ok;

  r_state_t              r_state_q, r_state_d;
  logic [IDX_W-1:0]      ar_idx;
  logic                  ar_hs;
  logic [DATA_WIDTH-1:0] rd_val;
  logic [1:0]            rd_resp;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  // Byte offsets, protection bits and unused hw_in slices carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot,
                         s00_axi_awaddr[ADDR_LSB-1:0], s00_axi_araddr[ADDR_LSB-1:0], hw_in};

  assign aw_hs = s00_axi_awvalid && s00_axi_awready;
  assign w_hs  = s00_axi_wvalid && s00_axi_wready;
  assign ar_hs = s00_axi_arvalid && s00_axi_arready;
  assign ar_idx = s00_axi_araddr[ADDR_WIDTH-1:ADDR_LSB];

  // Classify the latched write target: writable only if in range and not read-only.
  always_comb begin
    wr_ro = 1'b0;
    for (int i = 0; i < NUM_REGS; i++)
      if (aw_idx_q == IDX_W'(i)) wr_ro = RO_MASK[i];
    wr_ok = ({1'b0, aw_idx_q} < REG_CNT) && !wr_ro;
  end

  // Write FSM next state and handshake outputs; AW and W latch independently in idle.
  always_comb begin
    w_state_d       = w_state_q;
    s00_axi_awready = 1'b0;
    s00_axi_wready  = 1'b0;
    s00_axi_bvalid  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        s00_axi_awready = !aw_held_q && !s00_axi_areset;
        s00_axi_wready  = !w_held_q && !s00_axi_areset;
        if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) w_state_d = W_COMMIT;
      end
      W_COMMIT: w_state_d = W_RESP;
      W_RESP: begin
        s00_axi_bvalid = 1'b1;
        if (s00_axi_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write FSM state, address/data latches and the response code.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        aw_idx_q  <= s00_axi_awaddr[ADDR_WIDTH-1:ADDR_LSB];
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        wdata_q  <= s00_axi_wdata;
        wstrb_q  <= s00_axi_wstrb;
      end
      if (w_state_q == W_COMMIT) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bresp_q   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // Register storage: byte-lane update on the commit edge.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (w_state_q == W_COMMIT && wr_ok) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (aw_idx_q == IDX_W'(i))
          for (int b = 0; b < STRB_W; b++)
            if (wstrb_q[b]) regs[i][b*8 +: 8] <= wdata_q[b*8 +: 8];
    end
  end

  // One-cycle strobe while a real (non-empty) write commits.
  always_comb begin
    wr_pulse = '0;
    if (w_state_q == W_COMMIT && wr_ok && |wstrb_q)
      for (int i = 0; i < NUM_REGS; i++)
        if (aw_idx_q == IDX_W'(i)) wr_pulse[i] = 1'b1;
  end

  // Flatten storage onto reg_out.
  always_comb begin
    reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end

  assign s00_axi_bresp = bresp_q;

  // Read source select: storage for RW, hw_in for RO, zero plus SLVERR when out of range.
  always_comb begin
    rd_val  = '0;
    rd_resp = RESP_SLVERR;
    for (int i = 0; i < NUM_REGS; i++)
      if (ar_idx == IDX_W'(i)) begin
        rd_val  = RO_MASK[i] ? hw_in[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
        rd_resp = RESP_OKAY;
      end
  end

  // Read FSM next state and handshake outputs.
  always_comb begin
    r_state_d       = r_state_q;
    s00_axi_arready = 1'b0;
    s00_axi_rvalid  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        s00_axi_arready = !s00_axi_areset;
        if (ar_hs) r_state_d = R_RESP;
      end
      R_RESP: begin
        s00_axi_rvalid = 1'b1;
        if (s00_axi_rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read FSM state register.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) r_state_q <= R_IDLE;
    else                r_state_q <= r_state_d;
  end

  // Capture read data at the AR handshake; held until the R handshake.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_q <= rd_val;
      rresp_q <= rd_resp;
    end
  end

  assign s00_axi_rdata = rdata_q;
  assign s00_axi_rresp = rresp_q;

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Directed bench for axi_lite_regbank: 8 x 32-bit registers, register 1 read-only.
module tb_axi_lite_regbank;

  localparam int         NREGS = 8;
  localparam logic [7:0] RO    = 8'h02;

  logic        clk, areset;
  logic [7:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [NREGS*32-1:0] reg_out, hw_in;
  logic [NREGS-1:0]    wr_pulse;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  exp_t        b_q[$];
  exp_t        r_q[$];
  logic [31:0] model [NREGS];
  int          exp_pulse [NREGS];
  int          pulse_cnt [NREGS];
  int          n_tests = 0;
  int          n_fail  = 0;

  axi_lite_regbank #(
    .DATA_WIDTH(32), .NUM_REGS(NREGS), .ADDR_WIDTH(8), .RO_MASK(RO)
  ) dut (
    .s00_axi_aclk(clk), .s00_axi_areset(areset),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot),
    .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot),
    .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp),
    .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .reg_out(reg_out), .hw_in(hw_in), .wr_pulse(wr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < NREGS; i++) pulse_cnt[i] = 0;
  end

  always @(negedge clk) begin
    for (int i = 0; i < NREGS; i++)
      if (wr_pulse[i] === 1'b1) pulse_cnt[i] = pulse_cnt[i] + 1;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    for (int i = 0; i < NREGS; i++) begin
      check($sformatf("reg_out[%0d]", i), 64'(reg_out[i*32 +: 32]), 64'(model[i]));
      check($sformatf("pulse_cnt[%0d]", i), 64'(pulse_cnt[i]), 64'(exp_pulse[i]));
    end
  endtask

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead, input int hold);
    int   idx, cyc;
    bit   ok, aw_done, w_done, aw_fire, w_fire;
    exp_t e;
    idx = int'(addr[7:2]);
    ok  = 1'b0;
    if (idx < NREGS) ok = !RO[idx];
    e.resp = ok ? 2'b00 : 2'b10;
    e.data = '0;
    b_q.push_back(e);
    if (ok) begin
      for (int b = 0; b < 4; b++) if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
      if (|strb) exp_pulse[idx]++;
    end
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb; bready = 1'b0;
    wvalid = 1'b1; awvalid = (w_lead == 0);
    aw_done = 0; w_done = 0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 50) begin
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      @(negedge clk);
      cyc++;
      if (aw_fire) begin aw_done = 1; awvalid = 1'b0; end
      if (w_fire)  begin w_done  = 1; wvalid  = 1'b0; end
      if (!aw_done && cyc >= w_lead) awvalid = 1'b1;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("aw_w_handshake", 64'(aw_done && w_done), 64'd1);
    cyc = 0;
    while (!bvalid && cyc < 20) begin @(negedge clk); cyc++; end
    check("b_latency", 64'(cyc), 64'd1);
    for (int k = 0; k < hold; k++) begin
      check("hold_bvalid", 64'(bvalid), 64'd1);
      check("hold_bresp", 64'(bresp), 64'(e.resp));
      check("hold_awready", 64'(awready), 64'd0);
      check("hold_wready", 64'(wready), 64'd0);
      @(negedge clk);
    end
    bready = 1'b1;
    check("bvalid", 64'(bvalid), 64'd1);
    if (b_q.size() == 0) check("b_queue_nonempty", 64'd0, 64'd1);
    else begin
      e = b_q.pop_front();
      check("bresp", 64'(bresp), 64'(e.resp));
    end
    @(negedge clk);
    bready = 1'b0;
    check("bvalid_drop", 64'(bvalid), 64'd0);
    check_state();
  endtask

  task automatic axi_read(input logic [7:0] addr);
    int   idx, cyc;
    exp_t e;
    idx = int'(addr[7:2]);
    if (idx >= NREGS) begin e.resp = 2'b10; e.data = '0; end
    else begin
      e.resp = 2'b00;
      e.data = RO[idx] ? hw_in[idx*32 +: 32] : model[idx];
    end
    r_q.push_back(e);
    @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    cyc = 0;
    while (!arready && cyc < 20) begin @(negedge clk); cyc++; end
    check("ar_accept", 64'(arready), 64'd1);
    @(negedge clk);
    arvalid = 1'b0; rready = 1'b1;
    cyc = 0;
    while (!rvalid && cyc < 20) begin @(negedge clk); cyc++; end
    check("r_latency", 64'(cyc), 64'd0);
    if (r_q.size() == 0) check("r_queue_nonempty", 64'd0, 64'd1);
    else begin
      e = r_q.pop_front();
      check($sformatf("rdata@%0h", addr), 64'(rdata), 64'(e.data));
      check($sformatf("rresp@%0h", addr), 64'(rresp), 64'(e.resp));
    end
    @(negedge clk);
    rready = 1'b0;
    check("rvalid_drop", 64'(rvalid), 64'd0);
  endtask

  initial begin
    int bv_cnt;
    areset = 1'b1;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    wdata = '0; wstrb = '0;
    hw_in = '0;
    for (int i = 0; i < NREGS; i++) hw_in[i*32 +: 32] = 32'h1234_5600 + 32'(i);
    hw_in[32 +: 32] = 32'hDEAD_BEEF;
    for (int i = 0; i < NREGS; i++) begin model[i] = '0; exp_pulse[i] = 0; end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_awready", 64'(awready), 64'd0);
    check("rst_wready", 64'(wready), 64'd0);
    check("rst_arready", 64'(arready), 64'd0);
    check("rst_bvalid", 64'(bvalid), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_bresp", 64'(bresp), 64'd0);
    check("rst_rresp", 64'(rresp), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_wr_pulse", 64'(wr_pulse), 64'd0);
    check("rst_reg_out_lo", reg_out[63:0], 64'd0);
    areset = 1'b0;
    @(negedge clk);
    check("idle_awready", 64'(awready), 64'd1);
    check("idle_wready", 64'(wready), 64'd1);
    check("idle_arready", 64'(arready), 64'd1);

    // Basic writes/readbacks on RW registers
    axi_write(8'h00, 32'h1, 4'hF, 0, 0);
    axi_write(8'h08, 32'h2, 4'hF, 0, 0);
    axi_write(8'h0C, 32'h3, 4'hF, 0, 0);
    axi_write(8'h10, 32'h4, 4'hF, 0, 0);
    axi_read(8'h00);
    axi_read(8'h08);
    axi_read(8'h0C);
    axi_read(8'h10);
    check("rd_const_reg3", 64'(reg_out[3*32 +: 32]), 64'h3);

    // Byte strobes
    axi_write(8'h00, 32'hAABB_CCDD, 4'hF, 0, 0);
    axi_write(8'h00, 32'h1122_3344, 4'b0101, 0, 0);
    check("strb_merge", 64'(reg_out[31:0]), 64'hAA22_CC44);
    axi_read(8'h00);

    // Read-only register 1
    axi_write(8'h04, 32'h5, 4'hF, 0, 0);
    check("ro_no_pulse", 64'(pulse_cnt[1]), 64'd0);
    axi_read(8'h04);

    // Out-of-range index 8
    axi_write(8'h20, 32'hCAFE_F00D, 4'hF, 0, 0);
    axi_read(8'h20);

    // W three cycles ahead of AW, B held off five cycles
    axi_write(8'h14, 32'h5A5A_A5A5, 4'hF, 3, 5);
    check("late_aw_value", 64'(reg_out[5*32 +: 32]), 64'h5A5A_A5A5);
    axi_read(8'h14);

    // Reset right after the AW handshake, before any W
    @(negedge clk);
    awaddr = 8'h18; awvalid = 1'b1;
    check("mid_awready", 64'(awready), 64'd1);
    @(negedge clk);
    awvalid = 1'b0; areset = 1'b1;
    @(negedge clk);
    areset = 1'b0;
    for (int i = 0; i < NREGS; i++) model[i] = '0;
    bv_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bvalid) bv_cnt++;
    end
    check("mid_rst_no_bvalid", 64'(bv_cnt), 64'd0);
    check("mid_rst_wready", 64'(wready), 64'd1);
    check_state();

    // Normal traffic after the reset
    axi_write(8'h18, 32'h0BAD_CAFE, 4'hF, 0, 0);
    axi_read(8'h18);
    check("queues_drained", 64'(b_q.size() + r_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
